// File: rtl/multicycle_control_pkg.sv
// Shared core package for the multicycle control FSM and the ALU control decoder.
// It holds the state encoding, the opcode constants and the ALU operand/operation encodings.
// Optional feature macro: MCTRL_JAL_EN adds the JAL state and the decode of opcode 1101111.
package multicycle_control_pkg;

    // Controller states. JAL is only generated when the feature is enabled.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
`ifdef MCTRL_JAL_EN
        S_JAL      = 4'd9,
`endif
        S_ERROR    = 4'd10
    } state_t;

    // Opcodes (instruction[6:0]).
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ALU operation select.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU operand B select.
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    // ALU operand A select.
    localparam logic SRCA_PC  = 1'b0;
    localparam logic SRCA_RS1 = 1'b1;

    // States that issue a memory request and are therefore bounded by the wait timer.
    function automatic logic is_mem_state(input state_t st);
        logic res;
        case (st)
            S_FETCH, S_MEM_RD, S_MEM_WR: res = 1'b1;
            default:                     res = 1'b0;
        endcase
        return res;
    endfunction

    // Successor of DECODE for a given opcode; unknown opcodes trap to ERROR.
    function automatic state_t decode_opcode(input logic [6:0] op);
        state_t nxt;
        case (op)
            OP_LOAD, OP_STORE: nxt = S_MEM_ADDR;
            OP_RTYPE:          nxt = S_EXEC_R;
            OP_BRANCH:         nxt = S_BRANCH;
`ifdef MCTRL_JAL_EN
            OP_JAL:            nxt = S_JAL;
`else
            OP_JAL:            nxt = S_ERROR;
`endif
            default:           nxt = S_ERROR;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// Memory wait timer: counts consecutive cycles without mem_ready while a memory
// request is outstanding and flags the cycle in which the wait budget runs out.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CW          = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic count_en,
    output logic timeout
);

    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next_s;

    // Incremented value and timeout compare: the budget is spent when this
    // waiting cycle would bring the count up to MEM_TIMEOUT.
    always_comb begin
        count_next_s = count_r + CW'(1);
        timeout      = count_en && (count_next_s == CW'(MEM_TIMEOUT));
    end

    // Count while waiting, clear whenever the request completes or no request is pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CW{1'b0}};
        end else if (count_en) begin
            if (count_r != CW'(MEM_TIMEOUT)) begin
                count_r <= count_next_s;
            end else begin
                count_r <= count_r;
            end
        end else begin
            count_r <= {CW{1'b0}};
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle processor main control FSM (Moore, with mem_ready-qualified fetch strobes).
// Optional feature macro: MCTRL_JAL_EN enables the JAL state and opcode 1101111 decode;
// without it that opcode traps to ERROR.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       alu_err,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] ALUOp,
    output logic       flag_err
);
    import multicycle_control_pkg::*;

    state_t     state_r;
    logic [6:0] op_r;
    logic       in_mem_s;
    logic       timeout_s;

    logic       mem_req_s;
    logic       mem_we_s;
    logic       ir_write_s;
    logic       pc_write_s;
    logic       pc_write_cond_s;
    logic       reg_write_s;
    logic       mem_to_reg_s;
    logic       alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] alu_op_s;
    logic       flag_err_s;

    // A memory wait is in progress only inside a memory state.
    always_comb begin
        in_mem_s = is_mem_state(state_r);
    end

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .count_en(in_mem_s & ~mem_ready),
        .timeout (timeout_s)
    );

    // Main state register and opcode latch; reset overrides every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_FETCH;
            op_r    <= 7'd0;
        end else begin
            case (state_r)
                S_FETCH: begin
                    if (mem_ready) begin
                        state_r <= S_DECODE;
                    end else if (timeout_s) begin
                        state_r <= S_ERROR;
                    end else begin
                        state_r <= S_FETCH;
                    end
                end
                S_DECODE: begin
                    op_r    <= opcode;
                    state_r <= decode_opcode(opcode);
                end
                S_MEM_ADDR: begin
                    if (op_r == OP_LOAD) begin
                        state_r <= S_MEM_RD;
                    end else if (op_r == OP_STORE) begin
                        state_r <= S_MEM_WR;
                    end else begin
                        state_r <= S_ERROR;
                    end
                end
                S_MEM_RD: begin
                    if (mem_ready) begin
                        state_r <= S_MEM_WB;
                    end else if (timeout_s) begin
                        state_r <= S_ERROR;
                    end else begin
                        state_r <= S_MEM_RD;
                    end
                end
                S_MEM_WR: begin
                    if (mem_ready) begin
                        state_r <= S_FETCH;
                    end else if (timeout_s) begin
                        state_r <= S_ERROR;
                    end else begin
                        state_r <= S_MEM_WR;
                    end
                end
                S_MEM_WB: state_r <= S_FETCH;
                S_EXEC_R: begin
                    if (alu_err) begin
                        state_r <= S_ERROR;
                    end else begin
                        state_r <= S_R_WB;
                    end
                end
                S_R_WB:   state_r <= S_FETCH;
                S_BRANCH: state_r <= S_FETCH;
`ifdef MCTRL_JAL_EN
                S_JAL:    state_r <= S_FETCH;
`else
`endif
                S_ERROR:  state_r <= S_ERROR;
                default:  state_r <= S_ERROR;
            endcase
        end
    end

    // Decode control strobes from the registered state.
    always_comb begin
        mem_req_s       = 1'b0;
        mem_we_s        = 1'b0;
        ir_write_s      = 1'b0;
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        reg_write_s     = 1'b0;
        mem_to_reg_s    = 1'b0;
        alu_src_a_s     = SRCA_PC;
        alu_src_b_s     = SRCB_RS2;
        alu_op_s        = ALUOP_ADD;
        flag_err_s      = 1'b0;
        case (state_r)
            S_FETCH: begin
                mem_req_s   = 1'b1;
                alu_src_b_s = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write_s = 1'b1;
                    pc_write_s = 1'b1;
                end else begin
                    ir_write_s = 1'b0;
                    pc_write_s = 1'b0;
                end
            end
            S_DECODE: begin
                alu_src_b_s = SRCB_IMM;
            end
            S_MEM_ADDR: begin
                alu_src_a_s = SRCA_RS1;
                alu_src_b_s = SRCB_IMM;
            end
            S_MEM_RD: begin
                mem_req_s = 1'b1;
            end
            S_MEM_WR: begin
                mem_req_s = 1'b1;
                mem_we_s  = 1'b1;
            end
            S_MEM_WB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a_s = SRCA_RS1;
                alu_op_s    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                reg_write_s = 1'b1;
                alu_op_s    = ALUOP_FUNCT;
            end
            S_BRANCH: begin
                alu_src_a_s     = SRCA_RS1;
                alu_op_s        = ALUOP_SUB;
                pc_write_cond_s = 1'b1;
            end
`ifdef MCTRL_JAL_EN
            S_JAL: begin
                alu_src_b_s = SRCB_FOUR;
                reg_write_s = 1'b1;
                pc_write_s  = 1'b1;
            end
`else
`endif
            S_ERROR: begin
                flag_err_s = 1'b1;
            end
            default: begin
                flag_err_s = 1'b1;
            end
        endcase
    end

    // While reset is held every output is forced inactive.
    always_comb begin
        if (rst) begin
            mem_req       = 1'b0;
            mem_we        = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            reg_write     = 1'b0;
            mem_to_reg    = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            ALUOp         = 2'b00;
            flag_err      = 1'b0;
        end else begin
            mem_req       = mem_req_s;
            mem_we        = mem_we_s;
            ir_write      = ir_write_s;
            pc_write      = pc_write_s;
            pc_write_cond = pc_write_cond_s;
            reg_write     = reg_write_s;
            mem_to_reg    = mem_to_reg_s;
            alu_src_a     = alu_src_a_s;
            alu_src_b     = alu_src_b_s;
            ALUOp         = alu_op_s;
            flag_err      = flag_err_s;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control (default MEM_TIMEOUT=16).
// Outputs are packed as {mem_req, mem_we, ir_write, pc_write, pc_write_cond,
// reg_write, mem_to_reg, alu_src_a, alu_src_b[1:0], ALUOp[1:0], flag_err}.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic       mem_ready = 1'b0;
    logic       alu_err = 1'b0;
    logic       mem_req, mem_we, ir_write, pc_write, pc_write_cond;
    logic       reg_write, mem_to_reg, alu_src_a, flag_err;
    logic [1:0] alu_src_b, ALUOp;

    int pass_cnt = 0;
    int total_cnt = 0;
    int mreq_cnt = 0;
    int cyc_cnt = 0;

    localparam logic [12:0] E_ZERO      = 13'b0_0_0_0_0_0_0_0_00_00_0;
    localparam logic [12:0] E_FETCH     = 13'b1_0_0_0_0_0_0_0_01_00_0;
    localparam logic [12:0] E_FETCH_RDY = 13'b1_0_1_1_0_0_0_0_01_00_0;
    localparam logic [12:0] E_DECODE    = 13'b0_0_0_0_0_0_0_0_10_00_0;
    localparam logic [12:0] E_MADDR     = 13'b0_0_0_0_0_0_0_1_10_00_0;
    localparam logic [12:0] E_MRD       = 13'b1_0_0_0_0_0_0_0_00_00_0;
    localparam logic [12:0] E_MWR       = 13'b1_1_0_0_0_0_0_0_00_00_0;
    localparam logic [12:0] E_MWB       = 13'b0_0_0_0_0_1_1_0_00_00_0;
    localparam logic [12:0] E_EXEC      = 13'b0_0_0_0_0_0_0_1_00_10_0;
    localparam logic [12:0] E_RWB       = 13'b0_0_0_0_0_1_0_0_00_10_0;
    localparam logic [12:0] E_BR        = 13'b0_0_0_0_1_0_0_1_00_01_0;
    localparam logic [12:0] E_JAL       = 13'b0_0_0_1_0_1_0_0_01_00_0;
    localparam logic [12:0] E_ERR       = 13'b0_0_0_0_0_0_0_0_00_00_1;

    logic [12:0] outs;
    assign outs = {mem_req, mem_we, ir_write, pc_write, pc_write_cond, reg_write,
                   mem_to_reg, alu_src_a, alu_src_b, ALUOp, flag_err};

    multicycle_control dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .mem_ready    (mem_ready),
        .alu_err      (alu_err),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_write_cond(pc_write_cond),
        .reg_write    (reg_write),
        .mem_to_reg   (mem_to_reg),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .ALUOp        (ALUOp),
        .flag_err     (flag_err)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: apply mem_ready, check the decoded outputs, advance past the edge.
    task automatic cyc(input string tag, input logic rdy, input logic [12:0] exp);
        mem_ready = rdy;
        #1;
        check_val(tag, {19'd0, outs}, {19'd0, exp});
        if (outs[12]) mreq_cnt++;
        cyc_cnt++;
        @(posedge clk);
        #1;
    endtask

    // Reset pulse of one edge, then release; outputs must read all-zero while held.
    task automatic rst_pulse(input string tag);
        rst = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        check_val({tag, "_held"}, {19'd0, outs}, {19'd0, E_ZERO});
        rst = 1'b0;
    endtask

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_outs", {19'd0, outs}, {19'd0, E_ZERO});
        rst = 1'b0;
        // First cycle with rst=0 already requests memory.
        cyc("first_fetch", 1'b0, E_FETCH);

        // R-type add, 4 cycles; a stray mem_ready in DECODE/EXEC_R is ignored.
        opcode = 7'b0110011;
        cyc_cnt = 0;
        cyc("r_fetch", 1'b1, E_FETCH_RDY);
        cyc("r_decode", 1'b1, E_DECODE);
        cyc("r_exec", 1'b1, E_EXEC);
        cyc("r_wb", 1'b0, E_RWB);
        check_val("r_cycles", cyc_cnt, 32'd4);
        cyc("r_back_fetch", 1'b0, E_FETCH);

        // Load with 3-cycle ready delay in FETCH and MEM_RD: 11 cycles total.
        opcode = 7'b0000011;
        cyc_cnt = 1;
        mreq_cnt = 1;
        for (int i = 0; i < 2; i++) cyc("ld_fetch_wait", 1'b0, E_FETCH);
        cyc("ld_fetch_rdy", 1'b1, E_FETCH_RDY);
        check_val("ld_fetch_mreq", mreq_cnt, 32'd4);
        cyc("ld_decode", 1'b0, E_DECODE);
        cyc("ld_maddr", 1'b0, E_MADDR);
        mreq_cnt = 0;
        for (int i = 0; i < 3; i++) cyc("ld_mrd_wait", 1'b0, E_MRD);
        cyc("ld_mrd_rdy", 1'b1, E_MRD);
        check_val("ld_mrd_mreq", mreq_cnt, 32'd4);
        cyc("ld_mwb", 1'b0, E_MWB);
        check_val("ld_cycles", cyc_cnt, 32'd11);
        cyc("ld_back_fetch", 1'b0, E_FETCH);

        // Branch.
        opcode = 7'b1100011;
        cyc("br_fetch", 1'b1, E_FETCH_RDY);
        cyc("br_decode", 1'b0, E_DECODE);
        cyc("br_exec", 1'b0, E_BR);
        cyc("br_back_fetch", 1'b0, E_FETCH);

        // Store completing normally.
        opcode = 7'b0100011;
        cyc("st_fetch", 1'b1, E_FETCH_RDY);
        cyc("st_decode", 1'b0, E_DECODE);
        cyc("st_maddr", 1'b0, E_MADDR);
        cyc("st_mwr_rdy", 1'b1, E_MWR);
        cyc("st_back_fetch", 1'b0, E_FETCH);

        // Store timeout: 16 wait cycles in MEM_WR, then ERROR held.
        cyc("sto_fetch", 1'b1, E_FETCH_RDY);
        cyc("sto_decode", 1'b0, E_DECODE);
        cyc("sto_maddr", 1'b0, E_MADDR);
        mreq_cnt = 0;
        for (int i = 0; i < 16; i++) cyc("sto_mwr_wait", 1'b0, E_MWR);
        check_val("sto_wait_cycles", mreq_cnt, 32'd16);
        cyc("sto_error", 1'b0, E_ERR);
        cyc("sto_error_hold", 1'b1, E_ERR);
        cyc("sto_error_hold2", 1'b0, E_ERR);
        rst_pulse("sto_rst");
        cyc("sto_after_rst", 1'b0, E_FETCH);

        // Illegal opcode 0010111.
        opcode = 7'b0010111;
        cyc("ill_fetch", 1'b1, E_FETCH_RDY);
        cyc("ill_decode", 1'b0, E_DECODE);
        cyc("ill_error", 1'b0, E_ERR);
        rst_pulse("ill_rst");
        cyc("ill_after_rst", 1'b0, E_FETCH);

        // R-type with alu_err in EXEC_R.
        opcode = 7'b0110011;
        cyc("ae_fetch", 1'b1, E_FETCH_RDY);
        cyc("ae_decode", 1'b0, E_DECODE);
        alu_err = 1'b1;
        cyc("ae_exec", 1'b0, E_EXEC);
        alu_err = 1'b0;
        cyc("ae_error", 1'b0, E_ERR);
        rst_pulse("ae_rst");
        cyc("ae_after_rst", 1'b0, E_FETCH);

        // Reset during the second MEM_RD wait cycle.
        opcode = 7'b0000011;
        cyc("rm_fetch", 1'b1, E_FETCH_RDY);
        cyc("rm_decode", 1'b0, E_DECODE);
        cyc("rm_maddr", 1'b0, E_MADDR);
        cyc("rm_mrd_wait1", 1'b0, E_MRD);
        rst = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_val("rm_fetch_after", {19'd0, outs}, {19'd0, E_FETCH});
        check_val("rm_count_zero", {27'd0, dut.u_timer.count_r}, 32'd0);
        @(posedge clk);
        #1;

        // JAL opcode.
        opcode = 7'b1101111;
        cyc("jal_fetch", 1'b1, E_FETCH_RDY);
        cyc("jal_decode", 1'b0, E_DECODE);
`ifdef MCTRL_JAL_EN
        cyc("jal_state", 1'b0, E_JAL);
        cyc("jal_back_fetch", 1'b0, E_FETCH);
`else
        cyc("jal_error", 1'b0, E_ERR);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Safety bound on simulation time.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, maximum cycles to wait for mem_ready in any memory state.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port opcode, input, 7, instruction[6:0] from the instruction register.
REQ-005 SHALL have port mem_ready, input, 1, memory completion strobe for the current request.
REQ-006 SHALL have port alu_err, input, 1, the illegal-funct flag from the ALU control decoder.
REQ-007 SHALL have ports mem_req and mem_we, output, 1 each, memory request and write enable.
REQ-008 SHALL have ports ir_write, pc_write, pc_write_cond, reg_write and mem_to_reg, output, 1 each.
REQ-009 SHALL have port alu_src_a, output, 1, where 0 selects PC and 1 selects rs1.
REQ-010 SHALL have port alu_src_b, output, 2, where 00 selects rs2, 01 selects constant 4 and 10 selects imm.
REQ-011 SHALL have port ALUOp, output, 2, where 00 is add, 01 is subtract and 10 is decode-by-funct.
REQ-012 SHALL have port flag_err, output, 1, a sticky error indication.

Function
REQ-013 SHALL implement a Moore FSM with states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB, BRANCH, JAL and ERROR; outputs depend only on state, except the wait-dependent strobes in REQ-014.
REQ-014 FETCH: mem_req=1, alu_src_a=0, alu_src_b=01, ALUOp=00; in the cycle mem_ready=1, ir_write=1 and pc_write=1 assert and the FSM goes to DECODE; otherwise it holds.
REQ-015 DECODE: alu_src_a=0, alu_src_b=10, ALUOp=00 (branch target precompute); next state by opcode: 0000011 and 0100011 to MEM_ADDR, 0110011 to EXEC_R, 1100011 to BRANCH, 1101111 to JAL (REQ-026), any other opcode to ERROR.
REQ-016 MEM_ADDR: alu_src_a=1, alu_src_b=10, ALUOp=00; next is MEM_RD for a load and MEM_WR for a store, using the opcode latched at DECODE.
REQ-017 MEM_RD: mem_req=1; goes to MEM_WB when mem_ready=1.
REQ-018 MEM_WR: mem_req=1, mem_we=1; goes to FETCH when mem_ready=1.
REQ-019 MEM_WB: reg_write=1, mem_to_reg=1; goes to FETCH.
REQ-020 EXEC_R: alu_src_a=1, alu_src_b=00, ALUOp=10; goes to ERROR if alu_err=1, else to R_WB.
REQ-021 R_WB: reg_write=1, mem_to_reg=0, ALUOp=10; goes to FETCH.
REQ-022 BRANCH: alu_src_a=1, alu_src_b=00, ALUOp=01, pc_write_cond=1; goes to FETCH.
REQ-023 ERROR: all strobes are 0 and flag_err=1; the FSM holds until rst.
REQ-024 A wait counter of width clog2(MEM_TIMEOUT+1) SHALL clear on entry to FETCH, MEM_RD and MEM_WR and increment each cycle that mem_ready=0; at MEM_TIMEOUT with mem_ready=0 the FSM goes to ERROR, while mem_ready=1 in that same cycle completes normally.
REQ-025 Per instruction, mem_req SHALL deassert in the cycle after mem_ready; a mem_ready arriving outside a memory state SHALL be ignored.

Reset
REQ-026 With MCTRL_JAL_EN defined, JAL: alu_src_a=0, alu_src_b=01, reg_write=1, mem_to_reg=0, pc_write=1 with the target taken from the DECODE-computed ALUOut; goes to FETCH.
REQ-027 On rst=1 at a clock edge: state=FETCH, wait counter=0, latched opcode=0, flag_err=0 and all strobes 0 in the following cycle; rst has priority over all transitions, including mid-memory-wait and ERROR.
REQ-028 The first mem_req after reset SHALL assert in the first cycle with rst=0.

Configuration
REQ-029 SHALL use macro MCTRL_JAL_EN: when defined, the JAL state and opcode 1101111 decode exist; when undefined, opcode 1101111 goes to ERROR and no JAL state is generated.

Structure
REQ-030 The state enumeration, opcode constants and ALUOp/alu_src_b encodings SHALL live in the shared core package, common with alu_control.
REQ-031 The wait counter with its timeout compare SHALL be a sub-module, mem_wait_timer.

Verification
REQ-032 R-type add with mem_ready=1 on the first FETCH cycle: FETCH, DECODE, EXEC_R, R_WB gives 4 cycles, with reg_write=1 only in R_WB.
REQ-033 Load with mem_ready delayed 3 cycles in both FETCH and MEM_RD: mem_req high for 4 cycles in each, total 11 cycles, mem_to_reg=1 in MEM_WB.
REQ-034 Store with mem_ready never asserted and MEM_TIMEOUT=16: ERROR entered after 16 wait cycles, flag_err=1 held, all strobes 0.
REQ-035 Opcode 0010111, or R-type with alu_err=1 in EXEC_R: ERROR, flag_err=1; a subsequent rst pulse gives FETCH with flag_err=0.
REQ-036 rst asserted during the second MEM_RD wait cycle: next cycle is FETCH with mem_req=1 and the counter at 0; the JAL opcode with and without MCTRL_JAL_EN gives JAL then FETCH, or ERROR, respectively.
